// File: rtl/demux1to9v.sv
// rtl/demux1to9v.sv - 1-to-9 valid/ready demux with one registered slot per destination
// Optional saturating drop counter enabled by macro DEMUX1TO9V_ERRCNT_EN
module demux1to9v #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] i,
    output logic [8:0]       out_valid,
    input  logic [8:0]       out_ready,
    output logic             err,
    output logic [7:0]       err_cnt
);

    logic             sel_ok;
    logic [8:0]       sel_oh;
    logic [8:0]       load;
    logic             accept;
    logic [WIDTH-1:0] data_q [9];
    logic [8:0]       valid_q;
    logic [8:0]       valid_d;
    logic             err_q;
    logic             err_d;

    // Only the selected port's slot gates acceptance; invalid selects are always taken and dropped.
    always_comb begin
        sel_ok   = (sel <= 4'd8);
        sel_oh   = sel_ok ? (9'd1 << sel) : 9'd0;
        in_ready = sel_ok ? |(sel_oh & (~valid_q | out_ready)) : 1'b1;
        accept   = in_valid & in_ready;
        load     = accept ? sel_oh : 9'd0;
        valid_d  = (valid_q & ~out_ready) | load;
        err_d    = accept & ~sel_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 9'd0;
            err_q   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int k = 0; k < 9; k++) begin
                if (load[k]) begin
                    data_q[k] <= din;
                end
            end
        end
    end

`ifdef DEMUX1TO9V_ERRCNT_EN
    logic [7:0] cnt_q;

    // Counts on the same edge that raises err, so err and the new count appear together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (err_d && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign a         = data_q[0];
    assign b         = data_q[1];
    assign c         = data_q[2];
    assign d         = data_q[3];
    assign e         = data_q[4];
    assign f         = data_q[5];
    assign g         = data_q[6];
    assign h         = data_q[7];
    assign i         = data_q[8];
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux1to9v.sv
// tb/tb_demux1to9v.sv - directed bench for demux1to9v with a per-cycle reference model
module tb_demux1to9v;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [3:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d, e, f, g, h, i;
    logic [8:0]  out_valid;
    logic [8:0]  out_ready;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_data [9];
    logic        m_valid [9];
    logic        m_err;
    int          m_cnt;

    logic [15:0] dut_d [9];

    always #5 clk = ~clk;

    demux1to9v #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .din(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .h(h), .i(i), .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .err_cnt(err_cnt)
    );

    assign dut_d[0] = a;
    assign dut_d[1] = b;
    assign dut_d[2] = c;
    assign dut_d[3] = d;
    assign dut_d[4] = e;
    assign dut_d[5] = f;
    assign dut_d[6] = g;
    assign dut_d[7] = h;
    assign dut_d[8] = i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        if (sel > 4'd8) return 1'b1;
        return !m_valid[int'(sel)] || out_ready[int'(sel)];
    endfunction

    function automatic logic [8:0] model_vvec();
        logic [8:0] v;
        for (int k = 0; k < 9; k++) v[k] = m_valid[k];
        return v;
    endfunction

    task automatic apply(input logic r, input logic [15:0] dn, input logic [3:0] s,
                         input logic iv, input logic [8:0] ordy);
        reset     = r;
        din       = dn;
        sel       = s;
        in_valid  = iv;
        out_ready = ordy;
    endtask

    // Advance one edge: the model consumes the inputs seen at that edge.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                m_data[k]  = 16'h0;
                m_valid[k] = 1'b0;
            end
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            acc = in_valid && model_rdy();
            for (int k = 0; k < 9; k++) begin
                if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
            end
            m_err = 1'b0;
            if (acc) begin
                if (sel <= 4'd8) begin
                    m_data[int'(sel)]  = din;
                    m_valid[int'(sel)] = 1'b1;
                end else begin
                    m_err = 1'b1;
`ifdef DEMUX1TO9V_ERRCNT_EN
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
`endif
                end
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_rdy()});
            chk("out_valid", {23'd0, out_valid}, {23'd0, model_vvec()});
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("err_cnt", {24'd0, err_cnt}, m_cnt);
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("data%0d", k), {16'd0, dut_d[k]}, {16'd0, m_data[k]});
            end
        end
    end

    initial begin
        int exp_cnt;
        apply(1'b1, 16'h0, 4'd0, 1'b0, 9'h0);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_out_valid", {23'd0, out_valid}, 32'h0);
        chk("rst_a", {16'd0, a}, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'h0);

        // Load port a, then confirm it blocks while full and undrained.
        apply(1'b0, 16'h000A, 4'd0, 1'b1, 9'h0);
        tick();
        chk("load_a", {16'd0, a}, 32'h000A);
        chk("load_a_valid", {23'd0, out_valid}, 32'h001);
        apply(1'b0, 16'h000C, 4'd0, 1'b1, 9'h0);
        #1;
        chk("a_blocked_rdy", {31'd0, in_ready}, 32'h0);
        tick();
        chk("a_held", {16'd0, a}, 32'h000A);

        // Another port is unaffected by a's blockage.
        apply(1'b0, 16'h000B, 4'd1, 1'b1, 9'h0);
        #1;
        chk("b_rdy", {31'd0, in_ready}, 32'h1);
        tick();
        chk("load_b", {16'd0, b}, 32'h000B);
        chk("b_keeps_a", {16'd0, a}, 32'h000A);
        chk("ab_valid", {23'd0, out_valid}, 32'h003);

        // Drain-and-load on port d keeps valid high with the new word.
        apply(1'b0, 16'h0007, 4'd3, 1'b1, 9'h0);
        tick();
        apply(1'b0, 16'h0011, 4'd3, 1'b1, 9'h008);
        #1;
        chk("d_pass_rdy", {31'd0, in_ready}, 32'h1);
        tick();
        chk("d_new", {16'd0, d}, 32'h0011);
        chk("d_valid", {23'd0, out_valid}, 32'h00B);

        // Drain a alone: valid drops, data held; ready on an empty port is harmless.
        apply(1'b0, 16'h0, 4'd0, 1'b0, 9'h031);
        tick();
        chk("a_drained", {23'd0, out_valid}, 32'h00A);
        chk("a_drained_data", {16'd0, a}, 32'h000A);

        // Invalid select is accepted, dropped, and flagged for one cycle.
        apply(1'b0, 16'h1234, 4'hA, 1'b1, 9'h0);
        #1;
        chk("inv_rdy", {31'd0, in_ready}, 32'h1);
        tick();
        chk("inv_err", {31'd0, err}, 32'h1);
        chk("inv_valid", {23'd0, out_valid}, 32'h00A);
`ifdef DEMUX1TO9V_ERRCNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("inv_cnt", {24'd0, err_cnt}, exp_cnt);
        apply(1'b0, 16'h5555, 4'hF, 1'b0, 9'h0);
        tick();
        chk("err_pulse_end", {31'd0, err}, 32'h0);

        // Empty port e ignores other ports' out_ready.
        apply(1'b0, 16'h0E0E, 4'd4, 1'b1, 9'h0);
        #1;
        chk("e_rdy", {31'd0, in_ready}, 32'h1);
        tick();

        // Fill every port, draining the selected one where already full.
        for (int k = 0; k < 9; k++) begin
            apply(1'b0, 16'h0100 + 16'(k), 4'(k), 1'b1, 9'(1 << k));
            tick();
        end
        chk("all_full", {23'd0, out_valid}, 32'h1FF);
        chk("i_word", {16'd0, i}, 32'h0108);

        // Reset overrides a simultaneous accept and drain.
        apply(1'b1, 16'hFFFF, 4'd2, 1'b1, 9'h1FF);
        tick();
        chk("rst_mid_valid", {23'd0, out_valid}, 32'h0);
        chk("rst_mid_a", {16'd0, a}, 32'h0);
        chk("rst_mid_i", {16'd0, i}, 32'h0);
        chk("rst_mid_err", {31'd0, err}, 32'h0);

        // 300 dropped words saturate the counter.
        for (int k = 0; k < 300; k++) begin
            apply(1'b0, 16'(k), 4'(9 + (k % 7)), 1'b1, 9'h0);
            tick();
        end
`ifdef DEMUX1TO9V_ERRCNT_EN
        exp_cnt = 255;
`else
        exp_cnt = 0;
`endif
        chk("cnt_sat", {24'd0, err_cnt}, exp_cnt);
        apply(1'b0, 16'h0, 4'd0, 1'b0, 9'h0);
        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1to9v.md
DEMUX1TO9V -- requirements
Module: demux1to9v

Interface
REQ-001 SHALL provide parameter: WIDTH, 16, data width of the input word and of each output port.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: din  input  WIDTH  input data word.
REQ-005 SHALL provide port: sel  input  4  destination select; 0..8 map to a..i; 9..15 are invalid.
REQ-006 SHALL provide port: in_valid  input  1  din/sel qualified this cycle.
REQ-007 SHALL provide port: in_ready  output  1  block accepts din/sel this cycle.
REQ-008 SHALL provide ports: a,b,c,d,e,f,g,h,i  output  WIDTH each  registered per-destination data.
REQ-009 SHALL provide port: out_valid  output  9  bit k qualifies output k (bit0=a ... bit8=i).
REQ-010 SHALL provide port: out_ready  input  9  bit k: downstream consumes output k.
REQ-011 SHALL provide port: err  output  1  one-cycle pulse: a word with invalid sel was dropped.
REQ-012 SHALL provide port: err_cnt  output  8  count of dropped words (see Configuration).

Function
REQ-013 SHALL hold one single-entry output register per destination (data + valid).
REQ-014 SHALL compute in_ready combinationally: 1 when sel>8; else ~out_valid[sel] | out_ready[sel].
REQ-015 SHALL accept a word when in_valid & in_ready; otherwise hold all internal state (except drains per REQ-017).
REQ-016 SHALL, on accept with sel=k<=8, load din into output k and set out_valid[k] on the next edge (latency 1 cycle).
REQ-017 SHALL clear out_valid[k] on an edge where out_valid[k] & out_ready[k] and no new word targets k.
REQ-018 SHALL, when drain and load hit port k on the same edge, keep out_valid[k]=1 and present the new word (full throughput, no bubble).
REQ-019 SHALL leave data of ports other than the selected one, and data of a drained port, unchanged (last value held, valid low).
REQ-020 SHALL, on accept with sel in 9..15, discard din, change no output register, and assert err for exactly the following cycle.
REQ-021 SHALL ignore sel and din when in_valid=0; err stays 0.
REQ-022 SHALL allow out_ready[k] asserted with out_valid[k]=0 without effect.
REQ-023 SHALL not depend on out_ready of non-selected ports for in_ready.

Reset
REQ-024 SHALL, on any rising edge with reset=1, set a..i=0, out_valid=0, err=0, err_cnt=0, overriding simultaneous accepts and drains.
REQ-025 SHALL drop any word pending in output registers when reset is asserted mid-operation; in_ready follows REQ-014 from the reset values.

Configuration
REQ-026 SHALL, with macro DEMUX1TO9V_ERRCNT_EN defined, increment err_cnt by 1 on each edge where err is set, saturating at 255; cleared only by reset.
REQ-027 SHALL, with DEMUX1TO9V_ERRCNT_EN undefined, keep the err_cnt port present and tied to 0; err behaviour unchanged.

Verification
REQ-028 SHALL cover: reset, then din=0x000A sel=0 in_valid=1 out_ready=0 -> next cycle a=0x000A, out_valid=9'h001; following cycle in_ready=0 for sel=0.
REQ-029 SHALL cover: out_valid[3]=1, out_ready[3]=1, new din=0x0011 sel=3 in_valid=1 -> in_ready=1, next cycle d=0x0011, out_valid[3] stays 1.
REQ-030 SHALL cover: sel=4'hA din=0x1234 in_valid=1 -> in_ready=1, next cycle err=1, all outputs/out_valid unchanged, err_cnt=1 (macro on) or 0 (macro off).
REQ-031 SHALL cover: port a full and blocked, sel=1 din=0x000B -> in_ready=1, b=0x000B next cycle while a holds its value.
REQ-032 SHALL cover: 300 invalid-sel words with macro on -> err_cnt saturates at 255.
REQ-033 SHALL cover: reset asserted while out_valid=9'h1FF and in_valid=1 -> next cycle all outputs 0, out_valid=0, err=0.
